pe_lane_scatter: RTL
====================

// Module: pe_lane_scatter
// PURPOSE
//  Serial-to-parallel lane packer for the pool_nl datapath: the inverse of the N_PE-to-1 reduction path.
//  Accepts one WIDTH-bit word per beat over valid/ready and assembles N_LANES words into one packed
//  vector, lane i at bits [i*WIDTH +: WIDTH]. Presents the vector to the PE array over valid/ready.
//  A short final packet (in_last) is zero-padded.
// PARAMETERS
//  N_LANES  32  lanes per packed vector (= N_PE); power of two, >=2
//  WIDTH    16  bits per lane (= WID_PE_BITS)
//  CNT_W    $clog2(N_LANES+1)  width of the lane counters (derived, localparam)
// PORTS
//  clk        in   1              single clock, all logic on posedge
//  rst_n      in   1              asynchronous, active-low reset
//  in_valid   in   1              input word valid
//  in_ready   out  1              block accepts word this cycle
//  in_data    in   WIDTH          input word
//  in_last    in   1              word closes current packet (qualified by in_valid)
//  out_valid  out  1              packed vector valid
//  out_ready  in   1              PE array accepts vector
//  out_data   out  N_LANES*WIDTH  packed vector, lane 0 = LSBs
//  out_count  out  CNT_W          number of real (non-pad) lanes in out_data, 1..N_LANES
// BEHAVIOUR
//  Reset: in_ready=0 during reset, 1 on first cycle after release; out_valid=0, out_data=0,
//   out_count=0, lane counter=0, FSM=FILL. Reset mid-packet discards partial data, no output.
//  Beat: in_valid&in_ready. Out transfer: out_valid&out_ready.
//  FSM FILL: in_ready=1. Beat writes in_data into lane[cnt], cnt++.
//   Packet closes on beat with cnt==N_LANES-1 or in_last=1.
//   Close with slot free (!out_valid | out_ready same cycle): next edge moves assembly to out slot,
//    unwritten lanes forced 0, out_count=cnt+1, out_valid=1, cnt=0, assembly cleared, stay FILL.
//   Close with slot busy: go HOLD.
//  FSM HOLD: in_ready=0. Assembly held intact. On out transfer: next edge moves held packet to slot
//   (out_valid stays 1), cnt=0, -> FILL.
//  Latency: closing beat at edge t -> out_valid at edge t+1. out_data/out_count stable while
//   out_valid & !out_ready.
//  Throughput: with out_ready=1, one packet per N_LANES beats, no bubbles; in_ready never drops.
//  Slot empties (out_valid->0) only on out transfer with no packet moving in that edge.
//  in_last with cnt==N_LANES-1: ordinary full packet, out_count=N_LANES.
//  in_last while cnt==0: one-lane packet, out_count=1.
//  in_valid=0 beats leave state unchanged; no timeout, partial packet waits indefinitely.
//  No arithmetic on data; words pass unmodified, no sign extension.
// CONFIGURATION
//  PE_SCATTER_BCAST_EN defined: extra port in_bcast (in, 1). Beat with in_bcast=1 while cnt==0
//   replicates in_data to all N_LANES lanes and closes the packet in one beat (out_count=N_LANES).
//   in_bcast with cnt!=0 ignored (normal beat). in_bcast and in_last together: bcast wins.
//  Undefined: port absent, no replication logic; behaviour exactly as above.
// STRUCTURE
//  pool_nl_pkg: lane width/count constants, FSM enum typedef {FILL, HOLD}, CNT_W helper.
//  Single module, no sub-module: assembly regs, lane counter, out slot and 2-state FSM in one file.
// TESTING
//  Reset: rst_n=0 mid-packet after 5 beats, release -> out_valid=0, next 32 beats 0..31 give lanes=0..31.
//  Full packet: 32 beats data=i, out_ready=1 -> out_valid 1 cycle after beat 31, lane i==i, out_count=32.
//  Short: 3 beats A,B,C with in_last on C -> lanes0..2=A,B,C, lanes3..31=0, out_count=3.
//  Backpressure: out_ready=0, send 64 beats -> first packet held stable, in_ready=0 after beat 63
//   (HOLD); out_ready=1 -> packets emitted in order, in_ready returns next cycle.
//  Streaming: out_ready=1, in_valid=1 for 128 beats -> 4 packets, in_ready constant 1.
//  Bcast (PE_SCATTER_BCAST_EN): in_bcast=1, data=0x00AB at cnt==0 -> all 32 lanes 0x00AB, out_count=32.

Source files
------------

// File: rtl/pe_lane_scatter_pkg.sv
// Shared constants, FSM state type and counter-width helper for the pool_nl lane scatter block.
// Build option PE_SCATTER_BCAST_EN (see pe_lane_scatter.sv) adds single-beat broadcast.
package pe_lane_scatter_pkg;

  localparam int N_LANES_DEF = 32;  // one lane per PE
  localparam int WIDTH_DEF   = 16;  // bits per PE word

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  // The counter must also hold N_LANES itself, which is the stored count of a held full packet.
  function automatic int cnt_width(input int n_lanes);
    return $clog2(n_lanes + 1);
  endfunction

endpackage

// File: rtl/pe_lane_scatter_if.sv
// Word-in / packed-vector-out handshake bundle for pe_lane_scatter.
// With PE_SCATTER_BCAST_EN defined the bundle also carries in_bcast.
interface pe_lane_scatter_if
  import pe_lane_scatter_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int WIDTH   = WIDTH_DEF
);
  localparam int CNT_W = cnt_width(N_LANES);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     in_last;
`ifdef PE_SCATTER_BCAST_EN
  logic                     in_bcast;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [N_LANES*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]         out_count;

  modport master (
`ifdef PE_SCATTER_BCAST_EN
    output in_bcast,
`endif
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
`ifdef PE_SCATTER_BCAST_EN
    input  in_bcast,
`endif
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/pe_lane_scatter.sv
// Serial-to-parallel lane packer: N_LANES words per vector, short packets zero-padded.
// Define PE_SCATTER_BCAST_EN to add in_bcast (replicate one word to every lane at cnt==0).
module pe_lane_scatter
  import pe_lane_scatter_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_lane_scatter_if.slave  bus
);
  localparam int CNT_W = cnt_width(N_LANES);
  localparam int VEC_W = N_LANES * WIDTH;

  fsm_e             state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VEC_W-1:0] asm_q;
  logic [VEC_W-1:0] asm_d;
  logic [VEC_W-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic [CNT_W-1:0] close_count;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             beat;
  logic             bcast_hit;
  logic             close;
  logic             slot_free;

`ifdef PE_SCATTER_BCAST_EN
  assign bcast_hit = bus.in_bcast && (cnt_q == '0);
`else
  assign bcast_hit = 1'b0;
`endif

  assign beat      = bus.in_valid && in_ready_q;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign close     = beat && (bcast_hit || bus.in_last || (cnt_q == CNT_W'(N_LANES - 1)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    asm_d       = asm_q;
    close_count = cnt_q + 1'b1;
    if (bcast_hit) begin
      asm_d       = {N_LANES{bus.in_data}};
      close_count = CNT_W'(N_LANES);
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (cnt_q == CNT_W'(i)) asm_d[i*WIDTH +: WIDTH] = bus.in_data;
      end
    end
  end

  // NOTE: the assembly register is reset (not left as free RAM) because zero-padding of short
  // packets relies on unwritten lanes already being zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (bus.out_ready) out_valid_q <= 1'b0;
          if (close && slot_free) begin
            out_data_q  <= asm_d;
            out_count_q <= close_count;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            asm_q       <= '0;
          end else if (close) begin
            // Slot still occupied: park the finished packet, cnt_q keeps its lane count.
            asm_q      <= asm_d;
            cnt_q      <= close_count;
            state_q    <= HOLD;
            in_ready_q <= 1'b0;
          end else if (beat) begin
            asm_q <= asm_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_data_q  <= asm_q;
            out_count_q <= cnt_q;
            cnt_q       <= '0;
            asm_q       <= '0;
            state_q     <= FILL;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule
